// File: rtl/reg_file.sv
// reg_file: 2**ADDR_W x DATA_W general-purpose register file.
// Two combinational read ports (A, B) and one synchronous write port.
// There is no handshake: the write port takes a write on every rising
// edge where WE is high, and the read ports are always valid.
// Reset clears the storage asynchronously. While rst is high both read
// ports therefore return zero, and writes are ignored.
module reg_file #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int BYPASS = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addrA,
  input  logic [ADDR_W-1:0] addrB,
  output logic [DATA_W-1:0] outA,
  output logic [DATA_W-1:0] outB,
  input  logic [ADDR_W-1:0] inAddr,
  input  logic [DATA_W-1:0] inData,
  input  logic              WE
);

  localparam int DEPTH     = 2 ** ADDR_W;
  localparam bit useBypass = (BYPASS != 0);

  logic [DATA_W-1:0] regs [DEPTH];

  // Storage: async clear on rst, otherwise a single write per enabled edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (WE) begin
      regs[inAddr] <= inData;
    end
  end

  // Read ports: zero-latency lookup. With forwarding enabled, a pending
  // write to the same address shows through before the edge. Forwarding
  // is suppressed during reset so that outputs stay at zero.
  always_comb begin
    outA = regs[addrA];
    outB = regs[addrB];
    if (useBypass && WE && !rst) begin
      if (addrA == inAddr) outA = inData;
      if (addrB == inAddr) outB = inData;
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: one instance without forwarding and one with
// forwarding, both driven by the same stimulus and checked against an
// array model through an expected-value queue.
module tb_reg_file;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 2 ** ADDR_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [ADDR_W-1:0] addrA, addrB, inAddr;
  logic [DATA_W-1:0] inData;
  logic              WE;
  logic [DATA_W-1:0] outA0, outB0, outA1, outB1;

  reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(0)) rf0 (
    .clk(clk), .rst(rst), .addrA(addrA), .addrB(addrB),
    .outA(outA0), .outB(outB0),
    .inAddr(inAddr), .inData(inData), .WE(WE)
  );

  reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(1)) rf1 (
    .clk(clk), .rst(rst), .addrA(addrA), .addrB(addrB),
    .outA(outA1), .outB(outB1),
    .inAddr(inAddr), .inData(inData), .WE(WE)
  );

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] model [DEPTH];

  // ---------------- scoreboard ----------------
  logic [DATA_W-1:0] exp_a0_q[$];
  logic [DATA_W-1:0] exp_b0_q[$];
  logic [DATA_W-1:0] exp_a1_q[$];
  logic [DATA_W-1:0] exp_b1_q[$];
  string             tag_q[$];
  event              check_ev;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic compare(input string tag, input string port,
                         input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s %s: got %h expected %h (t=%0t)", tag, port, act, exp, $time);
    end
  endtask

  // Monitor: whenever the driver presents a sample point, pop and compare.
  initial begin
    forever begin
      @(check_ev);
      while (tag_q.size() > 0) begin
        string t;
        t = tag_q.pop_front();
        compare(t, "outA/bp0", outA0, exp_a0_q.pop_front());
        compare(t, "outB/bp0", outB0, exp_b0_q.pop_front());
        compare(t, "outA/bp1", outA1, exp_a1_q.pop_front());
        compare(t, "outB/bp1", outB1, exp_b1_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Push the expected read data for the current inputs, then hand off.
  task automatic check_point(input string tag);
    logic [DATA_W-1:0] ea, eb, fa, fb;
    #1;
    ea = rst ? '0 : model[addrA];
    eb = rst ? '0 : model[addrB];
    fa = (!rst && WE && addrA == inAddr) ? inData : ea;
    fb = (!rst && WE && addrB == inAddr) ? inData : eb;
    exp_a0_q.push_back(ea);
    exp_b0_q.push_back(eb);
    exp_a1_q.push_back(fa);
    exp_b1_q.push_back(fb);
    tag_q.push_back(tag);
    -> check_ev;
    #1;
  endtask

  // One clock cycle: model commits on the rising edge, return at falling edge.
  task automatic tick();
    @(posedge clk);
    if (WE && !rst) model[inAddr] = inData;
    @(negedge clk);
  endtask

  task automatic write_cycle(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    WE = 1'b1; inAddr = a; inData = d;
    tick();
    WE = 1'b0;
  endtask

  task automatic read_pair(input string tag, input logic [ADDR_W-1:0] a,
                           input logic [ADDR_W-1:0] b);
    addrA = a; addrB = b;
    check_point(tag);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    addrA = '0; addrB = '0; inAddr = '0; inData = '0; WE = 1'b0;

    // Reset state, including a write attempt while rst is held.
    read_pair("reset_0_1", 3'd0, 3'd1);
    read_pair("reset_2_3", 3'd2, 3'd3);
    WE = 1'b1; inAddr = 3'd2; inData = 16'h5a5a;
    read_pair("reset_we_2", 3'd2, 3'd3);
    tick();
    WE = 1'b0;
    read_pair("reset_after_we", 3'd2, 3'd3);
    rst = 1'b0;
    tick();
    read_pair("post_reset", 3'd2, 3'd7);

    // Back-to-back writes.
    WE = 1'b1; inAddr = 3'd4; inData = 16'h00ff;
    tick();
    inAddr = 3'd5; inData = 16'h00ee;
    tick();
    WE = 1'b0;
    read_pair("b2b", 3'd4, 3'd5);

    // Write disable over several edges.
    WE = 1'b0; inAddr = 3'd4; inData = 16'h1234;
    repeat (4) tick();
    read_pair("we_off", 3'd4, 3'd4);

    // Dual-port same address.
    read_pair("same_addr", 3'd5, 3'd5);

    // Same-cycle read/write to address 3 (forwarding vs stored contents).
    WE = 1'b1; inAddr = 3'd3; inData = 16'hbeef;
    read_pair("rw3_pre", 3'd3, 3'd4);
    tick();
    WE = 1'b0;
    read_pair("rw3_post", 3'd3, 3'd4);

    // Fill all registers with ffff and read every pair.
    for (int i = 0; i < DEPTH; i++) write_cycle(i[ADDR_W-1:0], 16'hffff);
    for (int i = 0; i < DEPTH; i++)
      for (int j = 0; j < DEPTH; j++)
        read_pair("fill_ffff", i[ADDR_W-1:0], j[ADDR_W-1:0]);

    // Randomized traffic, with extra weight on same-address hazards.
    for (int n = 0; n < 300; n++) begin
      WE     = ($urandom_range(0, 3) != 0);
      inAddr = ADDR_W'($urandom_range(0, DEPTH - 1));
      inData = DATA_W'($urandom);
      addrA  = ADDR_W'($urandom_range(0, DEPTH - 1));
      addrB  = ADDR_W'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 3) == 0) addrA = inAddr;
      if ($urandom_range(0, 3) == 0) addrB = inAddr;
      check_point("random");
      tick();
    end
    WE = 1'b0;

    // Make sure every register holds nonzero data before the async reset.
    for (int i = 0; i < DEPTH; i++) write_cycle(i[ADDR_W-1:0], DATA_W'(16'h1000 + i));
    read_pair("pre_async", 3'd6, 3'd7);

    // Async reset pulse between edges: outputs must drop before any edge.
    #2;
    rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    read_pair("async_rst", 3'd6, 3'd7);
    read_pair("async_rst2", 3'd1, 3'd2);
    // A WE edge during reset must not write.
    WE = 1'b1; inAddr = 3'd2; inData = 16'habcd;
    read_pair("rst_we_pre", 3'd2, 3'd6);
    tick();
    WE = 1'b0;
    read_pair("rst_we_post", 3'd2, 3'd6);
    rst = 1'b0;
    tick();
    read_pair("rst_released", 3'd2, 3'd6);
    write_cycle(3'd2, 16'hc0de);
    read_pair("write_after_rst", 3'd2, 3'd6);

    // Drain check: the monitor must have consumed every expectation.
    #5;
    n_checks++;
    if (tag_q.size() != 0) begin
      n_fails++;
      $display("FAIL drain: got %0d pending expected 0", tag_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "time limit");
  end

endmodule
